// File: rtl/ram_scheduler_pkg.sv
// ram_sched_pkg: shared types and defaults for the BRAM scheduler.
//   state_e : scheduler FSM states (2-bit encoding)
//   grant_e : arbiter grant encoding
//   DEF_ADDR_W / DEF_DATA_W : default BRAM geometry
package ram_sched_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR      = 2'd1,
    ST_RD_ADDR = 2'd2,
    ST_RD_WAIT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } grant_e;

endpackage

// File: rtl/ram_scheduler_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter between the write (push) and
// read (pop) requesters.
//   clk, rst    : clock, synchronous active-high reset
//   wr_elig_i   : push requester is eligible this cycle
//   rd_elig_i   : pop requester is eligible this cycle
//   en_i        : scheduler can accept a grant this cycle (FSM idle)
//   grant_o     : GNT_NONE / GNT_WR / GNT_RD, only non-NONE while en_i
// last_wr remembers whether the most recent grant went to the writer; on a
// tie the other side wins. It resets to 0 so the writer wins the first tie.
module rr_arbiter2
  import ram_sched_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   wr_elig_i,
  input  logic   rd_elig_i,
  input  logic   en_i,
  output grant_e grant_o
);

  logic last_wr_q, last_wr_d;

  always_comb begin
    grant_o   = GNT_NONE;
    last_wr_d = last_wr_q;
    if (en_i) begin
      if (wr_elig_i && rd_elig_i) begin
        grant_o = last_wr_q ? GNT_RD : GNT_WR;
      end else if (wr_elig_i) begin
        grant_o = GNT_WR;
      end else if (rd_elig_i) begin
        grant_o = GNT_RD;
      end
      if (grant_o == GNT_WR) begin
        last_wr_d = 1'b1;
      end else if (grant_o == GNT_RD) begin
        last_wr_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_wr_q <= 1'b0;
    end else begin
      last_wr_q <= last_wr_d;
    end
  end

endmodule

// File: rtl/ram_scheduler.sv
// ram_scheduler: sequencer and arbiter for a single-port word BRAM used as a
// circular buffer between the RX byte packer (push) and TX byte splitter (pop).
//   clk, rst               : clock, synchronous active-high reset
//   push_req/push_data     : level request + word to store (held while req)
//   push_ack               : one-cycle pulse, word accepted
//   pop_req                : level request for next word
//   pop_data/pop_valid     : popped word, qualified by one-cycle pulse
//   full/empty/count       : committed occupancy (updates on grant edge)
//   ram_addr/ram_din/ram_we: BRAM port A drive
//   ram_dout               : BRAM read data, one-cycle registered latency
module ram_scheduler
  import ram_sched_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ELEMENTS = 65536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_req,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ack,
  input  logic              pop_req,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(ELEMENTS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ELEMENTS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W-1:0]   rptr_q, rptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
  logic                ram_we_q, ram_we_d;
  logic                push_ack_q, push_ack_d;
  logic                pop_valid_q, pop_valid_d;
  logic [DATA_W-1:0]   pop_data_q, pop_data_d;

  logic                full_w, empty_w;
  logic                wr_elig, rd_elig;
  grant_e              grant;

  // Wraps at ELEMENTS-1 so depths smaller than 2^ADDR_W work too.
  function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + ADDR_W'(1);
  endfunction

  assign full_w  = (count_q == FULL_CNT);
  assign empty_w = (count_q == '0);

  assign wr_elig = push_req && !full_w;
  // Masking with pop_valid stops a second pop being granted in the cycle the
  // splitter is still dropping its request after seeing the data.
  assign rd_elig = pop_req && !empty_w && !pop_valid_q;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .wr_elig_i (wr_elig),
    .rd_elig_i (rd_elig),
    .en_i      (state_q == ST_IDLE),
    .grant_o   (grant)
  );

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    ram_we_d    = 1'b0;
    push_ack_d  = 1'b0;
    pop_valid_d = 1'b0;
    pop_data_d  = pop_data_q;

    case (state_q)
      ST_IDLE: begin
        if (grant == GNT_WR) begin
          state_d    = ST_WR;
          ram_addr_d = wptr_q;
          ram_din_d  = push_data;
          ram_we_d   = 1'b1;
          push_ack_d = 1'b1;
          wptr_d     = ptr_next(wptr_q);
          count_d    = count_q + (ADDR_W + 1)'(1);
        end else if (grant == GNT_RD) begin
          state_d    = ST_RD_ADDR;
          ram_addr_d = rptr_q;
          rptr_d     = ptr_next(rptr_q);
          count_d    = count_q - (ADDR_W + 1)'(1);
        end
      end
      ST_WR: begin
        state_d = ST_IDLE;
      end
      ST_RD_ADDR: begin
        // BRAM samples ram_addr on this edge; data appears next cycle.
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        state_d     = ST_IDLE;
        pop_data_d  = ram_dout;
        pop_valid_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      ram_we_q    <= 1'b0;
      push_ack_q  <= 1'b0;
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      ram_we_q    <= ram_we_d;
      push_ack_q  <= push_ack_d;
      pop_valid_q <= pop_valid_d;
      pop_data_q  <= pop_data_d;
    end
  end

  assign push_ack  = push_ack_q;
  assign pop_valid = pop_valid_q;
  assign pop_data  = pop_data_q;
  assign full      = full_w;
  assign empty     = empty_w;
  assign count     = count_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_we    = ram_we_q;

endmodule

// File: doc/ram_scheduler.md
# ram_scheduler

Sequencer and arbiter for the single-port word BRAM between the RX byte packer and the TX byte splitter. It replaces the phase-based address mux, so receive and transmit can share the RAM concurrently. The RAM is managed as a circular word buffer: the packer pushes 32-bit words, the splitter pops them, and the scheduler owns both pointers, the occupancy count and every BRAM port access.

## Interface
- `ADDR_W`, 16, BRAM address width.
- `DATA_W`, 32, word width.
- `ELEMENTS`, 65536, buffer depth in words; power of two, ≤ 2^ADDR_W.

Ports:
- `clk`  in  1  system clock; the block uses one clock.
- `rst`  in  1  reset; synchronous, active-high.
- `push_req`  in  1  level; packer has a word to store.
- `push_data`  in  DATA_W  word to store; held stable while push_req is high.
- `push_ack`  out  1  one-cycle pulse; the word has been accepted.
- `pop_req`  in  1  level; splitter wants the next word.
- `pop_data`  out  DATA_W  popped word; valid while pop_valid is high.
- `pop_valid`  out  1  one-cycle pulse.
- `full`  out  1  count == ELEMENTS.
- `empty`  out  1  count == 0.
- `count`  out  ADDR_W+1  committed word occupancy.
- `ram_addr`  out  ADDR_W  BRAM port A address.
- `ram_din`  out  DATA_W  BRAM write data.
- `ram_we`  out  1  BRAM write enable.
- `ram_dout`  in  DATA_W  BRAM read data; one-cycle registered latency.

## Operation
- FSM states: IDLE, WR, RD_ADDR, RD_WAIT. The block starts a new grant only in IDLE.
- Eligibility:
  - push is eligible when push_req && !full.
  - pop is eligible when pop_req && !empty && !pop_valid. The pop_valid mask prevents a double pop while the requester drops its request.
- Arbitration:
  - If only one requester is eligible, grant it.
  - If both are eligible, grant the requester that did not win the previous contested or uncontested grant, tracked by the flag `last_wr`.
  - Reset state of `last_wr` is 0, so write wins the first tie.
- Push grant: IDLE→WR.
  - Register ram_addr=wptr, ram_din=push_data, ram_we=1, push_ack=1.
  - wptr+1 (wraps mod ELEMENTS) and count+1.
  - WR→IDLE unconditionally; ram_we and push_ack clear.
- Pop grant: IDLE→RD_ADDR.
  - Register ram_addr=rptr, ram_we=0.
  - rptr+1 (wraps mod ELEMENTS) and count−1.
  - Then RD_ADDR→RD_WAIT→IDLE. On the RD_WAIT→IDLE edge, pop_data←ram_dout and pop_valid=1.
- Requester rules:
  - push_req and pop_req drop in the cycle after push_ack/pop_valid is seen.
  - A request still high after that cycle is a new request.
- Full: push_req waits and no ack is issued. Empty: pop_req waits. Neither condition is an error.
- The same-cycle write of a word and request to pop it is legal. The pop is granted only after count includes the word, at least one IDLE later.
- Reset in any state, including mid-read: next state IDLE, pending operation dropped.

## Timing
- Edge n is a grant edge in IDLE.
- Push:
  - ram_we, ram_addr, ram_din and push_ack are high for exactly n..n+1.
  - BRAM writes at edge n+1.
  - Earliest next grant is edge n+2; push throughput is one word per 2 cycles.
- Pop:
  - ram_addr=rptr from edge n; BRAM samples at n+1.
  - pop_valid is high for n+2..n+3.
  - Earliest next pop grant is edge n+4; a push may be granted at n+3.
- count, full and empty update on the grant edge.
- Reset values: push_ack=0, pop_valid=0, pop_data=0, ram_we=0, ram_addr=0, ram_din=0, count=0, empty=1, full=0, wptr=rptr=0, last_wr=0.
- Pointers: ADDR_W bits with natural wrap (ELEMENTS = 2^ADDR_W). Smaller ELEMENTS wraps at ELEMENTS−1→0.

## Structure
- Shared package `ram_sched_pkg`:
  - FSM state localparams (2-bit encoding).
  - grant encoding (NONE/WR/RD).
  - default ADDR_W/DATA_W.
- One sub-module, `rr_arbiter2`: 2-way round-robin with eligibility inputs, grant outputs and the last_wr register. The top holds the FSM, pointers, count and BRAM port registers.

## Test plan
- Reset, then 3 pushes (0xA1, 0xB2, 0xC3) with pop idle → ram_we pulses at addresses 0,1,2, three push_acks 2 cycles apart, count=3.
- Then 3 pops → pop_data 0xA1, 0xB2, 0xC3 in order, each pop_valid 2 cycles after grant, count=0, empty=1, no extra pop.
- Both requests held continuously → grants alternate W,R,W,R starting with W; no starvation over 100 grants.
- Fill to ELEMENTS=4, then push 0xEE → no push_ack while full=1. After one pop, 0xEE is acked and written at wrapped address 0.
- Pop while empty, then single push 0x55 → pop is granted only after push_ack, returns 0x55, and ram_addr for the read is 0.
- rst asserted in RD_WAIT → no pop_valid, all outputs at reset values next cycle, and the subsequent push writes address 0.
